// File: rtl/rgb2videoaxis_buf_if.sv
// AXI4-Stream video link: pixel beat with start-of-frame (tuser) and end-of-line (tlast).
interface rgb2videoaxis_buf_if #(
  parameter int unsigned DATA_W = 24
) ();
  logic [DATA_W-1:0] tdata;
  logic              tuser;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tuser, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tuser, input tlast, input tvalid, output tready);
endinterface

// File: rtl/rgb2videoaxis_buf.sv
// Parallel RGB video to AXI4-Stream video through a FWFT FIFO with backpressure,
// clean line truncation on overflow and active-resolution measurement.
module rgb2videoaxis_buf #(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 12,
  parameter bit          HSYNC_POL  = 1'b1,
  parameter bit          VSYNC_POL  = 1'b0,
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                vid_clk,
  input  logic                rst_n,
  input  logic                hsync,
  input  logic                vsync,
  input  logic                de,
  input  logic [DATA_W-1:0]   rgb_data,
  rgb2videoaxis_buf_if.master m_axis,
  input  logic                clr_overflow,
  output logic                overflow,
  output logic [LVL_W-1:0]    fifo_level,
  output logic [CNT_W-1:0]    h_active,
  output logic [CNT_W-1:0]    v_active,
  output logic                res_valid
);

  localparam int unsigned PTR_W = LVL_W - 1;
  localparam int unsigned ENT_W = DATA_W + 2;
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [LVL_W-1:0] DepthL = LVL_W'(FIFO_DEPTH);

  // Line boundaries come from de alone; hsync is only normalised.
  logic unused_hs;
  assign unused_hs = hsync ^ HSYNC_POL;

  logic vs, vs_q, vs_rise;
  assign vs      = vsync ~^ VSYNC_POL;
  assign vs_rise = vs & ~vs_q;

  logic              s1_de_q;
  logic [DATA_W-1:0] s1_data_q;
  logic              line_end;
  assign line_end = s1_de_q & ~de;

  logic [LVL_W-1:0] level_q, level_d, free;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0] rd_ent;
  logic push, pop, push_last, ovf_set;
  logic drop_line_q, drop_line_d, sof_q, sof_d, overflow_q;
  logic [CNT_W-1:0] h_cnt_q, v_cnt_q, h_inc, v_inc, h_active_q, v_active_q;
  logic vs_seen_q, res_valid_q;

  assign free = DepthL - level_q;
  assign pop  = m_axis.tvalid & m_axis.tready;

  // Free space is taken before any same-cycle pop so drop decisions never depend on tready.
  always_comb begin
    push        = 1'b0;
    push_last   = ~de;
    ovf_set     = 1'b0;
    drop_line_d = drop_line_q;
    if (s1_de_q) begin
      if (drop_line_q) begin
        ovf_set = 1'b1;
      end else if (free == '0) begin
        ovf_set     = 1'b1;
        drop_line_d = ~line_end;
      end else if (free >= LVL_W'(2) || line_end) begin
        push = 1'b1;
      end else begin
        push        = 1'b1;
        push_last   = 1'b1;
        drop_line_d = 1'b1;
        ovf_set     = 1'b1;
      end
    end
    if (line_end || vs_rise) drop_line_d = 1'b0;
  end

  always_comb begin
    sof_d = sof_q;
    if (push && sof_q) sof_d = 1'b0;
    if (vs_rise) sof_d = 1'b1;
  end

  assign level_d = level_q + LVL_W'(push) - LVL_W'(pop);
  assign h_inc   = (h_cnt_q == CntMax) ? h_cnt_q : h_cnt_q + 1'b1;
  assign v_inc   = (v_cnt_q == CntMax) ? v_cnt_q : v_cnt_q + 1'b1;

  always_ff @(posedge vid_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q        <= 1'b0;
      s1_de_q     <= 1'b0;
      s1_data_q   <= '0;
      level_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      drop_line_q <= 1'b0;
      sof_q       <= 1'b1;
      overflow_q  <= 1'b0;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      h_active_q  <= '0;
      v_active_q  <= '0;
      vs_seen_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      vs_q        <= vs;
      s1_de_q     <= de;
      s1_data_q   <= rgb_data;
      level_q     <= level_d;
      drop_line_q <= drop_line_d;
      sof_q       <= sof_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (ovf_set)           overflow_q <= 1'b1;
      else if (clr_overflow) overflow_q <= 1'b0;
      if (line_end) begin
        h_active_q <= h_inc;
        h_cnt_q    <= '0;
      end else if (s1_de_q) begin
        h_cnt_q <= h_inc;
      end
      if (vs_rise) begin
        v_active_q <= v_cnt_q;
        v_cnt_q    <= '0;
        vs_seen_q  <= 1'b1;
        if (vs_seen_q) res_valid_q <= 1'b1;
      end else if (line_end) begin
        v_cnt_q <= v_inc;
      end
    end
  end

  always_ff @(posedge vid_clk) begin
    if (push) mem_q[wr_ptr_q] <= {sof_q, push_last, s1_data_q};
  end

  // Gating by tvalid keeps the bus at zero while empty or in reset.
  assign rd_ent        = mem_q[rd_ptr_q];
  assign m_axis.tvalid = (level_q != '0);
  assign m_axis.tdata  = m_axis.tvalid ? rd_ent[DATA_W-1:0] : '0;
  assign m_axis.tlast  = m_axis.tvalid & rd_ent[DATA_W];
  assign m_axis.tuser  = m_axis.tvalid & rd_ent[DATA_W+1];

  assign overflow   = overflow_q;
  assign fifo_level = level_q;
  assign h_active   = h_active_q;
  assign v_active   = v_active_q;
  assign res_valid  = res_valid_q;

endmodule
